inst_fifo: RTL and testbench

- Dual-issue instruction queue between the fetch stage and the two decoders.
- Fetch pushes 0-2 instruction words per cycle; the decoders pop 0-2 per cycle from the head.
- The oldest entry is presented on the master slot and the next-oldest on the slave slot, first-word fall-through.
- Decouples I-cache latency and stalls from issue. It is flushed on branch mispredict or exception.

---
 rtl/inst_fifo.sv | 113 +++++++++++
 tb/tb_inst_fifo.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/inst_fifo.sv
// Dual-issue instruction queue between fetch and the two decoders.
// Oldest entry is shown on the master slot, the next-oldest on the slave slot (first-word fall-through).
module inst_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             write_en1,
  input  logic             write_en2,
  input  logic [31:0]      write_pc1,
  input  logic [31:0]      write_pc2,
  input  logic [31:0]      write_inst1,
  input  logic [31:0]      write_inst2,
  input  logic             write_excp1,
  input  logic             write_excp2,
  input  logic             read_en1,
  input  logic             read_en2,
  output logic             master_valid,
  output logic [31:0]      master_pc,
  output logic [31:0]      master_inst,
  output logic             master_excp,
  output logic             slave_valid,
  output logic [31:0]      slave_pc,
  output logic [31:0]      slave_inst,
  output logic             slave_excp,
  output logic             almost_full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SPC_W = PTR_W + 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        excp;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   cnt;

  logic [1:0]         n_rd;
  logic [1:0]         n_wr;
  logic [SPC_W-1:0]   space;
  logic               acc1;
  logic               acc2;
  entry_t             head;
  entry_t             second;

  // Effective pop: read_en2 only counts alongside read_en1 and a second entry.
  always_comb begin
    n_rd = 2'd0;
    if (read_en1 && read_en2 && (cnt >= CNT_W'(2))) begin
      n_rd = 2'd2;
    end else if (read_en1 && (cnt != '0)) begin
      n_rd = 2'd1;
    end
  end

  // Same-cycle pops free space for pushes; overflowing entries are dropped.
  always_comb begin
    space = SPC_W'(DEPTH) - SPC_W'(cnt) + SPC_W'(n_rd);
    acc1  = write_en1 && (space >= SPC_W'(1));
    acc2  = write_en1 && write_en2 && (space >= SPC_W'(2));
    n_wr  = 2'({1'b0, acc1}) + 2'({1'b0, acc2});
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(n_wr);
      rd_ptr <= rd_ptr + PTR_W'(n_rd);
      cnt    <= cnt + CNT_W'(n_wr) - CNT_W'(n_rd);
    end
  end

  // Storage has no reset; contents are only observed through valid slots.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (acc1) mem[wr_ptr] <= '{pc: write_pc1, inst: write_inst1, excp: write_excp1};
      if (acc2) mem[wr_ptr + PTR_W'(1)] <= '{pc: write_pc2, inst: write_inst2, excp: write_excp2};
    end
  end

  always_comb begin
    head         = mem[rd_ptr];
    second       = mem[rd_ptr + PTR_W'(1)];
    master_valid = (cnt != '0);
    slave_valid  = (cnt >= CNT_W'(2));
    master_pc    = master_valid ? head.pc   : 32'd0;
    master_inst  = master_valid ? head.inst : 32'd0;
    master_excp  = master_valid && head.excp;
    slave_pc     = slave_valid  ? second.pc   : 32'd0;
    slave_inst   = slave_valid  ? second.inst : 32'd0;
    slave_excp   = slave_valid && second.excp;
    almost_full  = (cnt >= CNT_W'(DEPTH - 2));
    empty        = (cnt == '0);
    count        = cnt;
  end

endmodule

// File: tb/tb_inst_fifo.sv
// Scoreboard bench for inst_fifo: a queue of expected entries is updated as stimulus is driven
// and compared against the master/slave slots and status after every clock.
module tb_inst_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned PTR_W = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        write_en1, write_en2;
  logic [31:0] write_pc1, write_pc2, write_inst1, write_inst2;
  logic        write_excp1, write_excp2;
  logic        read_en1, read_en2;
  logic        master_valid, slave_valid, master_excp, slave_excp;
  logic [31:0] master_pc, master_inst, slave_pc, slave_inst;
  logic        almost_full, empty;
  logic [PTR_W:0] count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        excp;
  } ent_t;

  ent_t        sb[$];
  int          n_err = 0;
  int          n_checks = 0;
  logic [31:0] next_pc;
  logic [31:0] saved_pc;

  inst_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .write_en1(write_en1), .write_en2(write_en2),
    .write_pc1(write_pc1), .write_pc2(write_pc2),
    .write_inst1(write_inst1), .write_inst2(write_inst2),
    .write_excp1(write_excp1), .write_excp2(write_excp2),
    .read_en1(read_en1), .read_en2(read_en2),
    .master_valid(master_valid), .master_pc(master_pc),
    .master_inst(master_inst), .master_excp(master_excp),
    .slave_valid(slave_valid), .slave_pc(slave_pc),
    .slave_inst(slave_inst), .slave_excp(slave_excp),
    .almost_full(almost_full), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h2402_0001;
  endfunction

  // Compare every output against the scoreboard head.
  task automatic check_outputs(input string tag);
    int n;
    n = sb.size();
    chk({tag, ".mv"},  32'(master_valid), 32'(n >= 1));
    chk({tag, ".mpc"}, master_pc,   (n >= 1) ? sb[0].pc   : 32'd0);
    chk({tag, ".mi"},  master_inst, (n >= 1) ? sb[0].inst : 32'd0);
    chk({tag, ".me"},  32'(master_excp), (n >= 1) ? 32'(sb[0].excp) : 32'd0);
    chk({tag, ".sv"},  32'(slave_valid), 32'(n >= 2));
    chk({tag, ".spc"}, slave_pc,   (n >= 2) ? sb[1].pc   : 32'd0);
    chk({tag, ".si"},  slave_inst, (n >= 2) ? sb[1].inst : 32'd0);
    chk({tag, ".se"},  32'(slave_excp), (n >= 2) ? 32'(sb[1].excp) : 32'd0);
    chk({tag, ".cnt"}, 32'(count), 32'(n));
    chk({tag, ".emp"}, 32'(empty), 32'(n == 0));
    chk({tag, ".af"},  32'(almost_full), 32'(n >= DEPTH - 2));
  endtask

  // Drive one cycle of stimulus, update the scoreboard, then check after the edge.
  task automatic cycle(input string tag, input logic we1, input logic we2,
                       input logic re1, input logic re2, input logic fl);
    int   nrd;
    ent_t e1, e2;
    e1.pc = next_pc;          e1.inst = inst_of(e1.pc); e1.excp = e1.pc[2] ^ e1.pc[5];
    e2.pc = next_pc + 32'd4;  e2.inst = inst_of(e2.pc); e2.excp = e2.pc[2] ^ e2.pc[5];
    write_en1 = we1; write_en2 = we2; read_en1 = re1; read_en2 = re2; flush = fl;
    write_pc1 = e1.pc; write_inst1 = e1.inst; write_excp1 = e1.excp;
    write_pc2 = e2.pc; write_inst2 = e2.inst; write_excp2 = e2.excp;
    if (we1) next_pc = next_pc + (we2 ? 32'd8 : 32'd4);
    if (fl) begin
      sb.delete();
    end else begin
      nrd = (re1 && re2 && sb.size() >= 2) ? 2 : ((re1 && sb.size() >= 1) ? 1 : 0);
      repeat (nrd) void'(sb.pop_front());
      if (we1 && (DEPTH - sb.size()) >= 1) sb.push_back(e1);
      if (we1 && we2 && (DEPTH - sb.size()) >= 1) sb.push_back(e2);
    end
    @(posedge clk);
    #1;
    write_en1 = 1'b0; write_en2 = 1'b0; read_en1 = 1'b0; read_en2 = 1'b0; flush = 1'b0;
    check_outputs(tag);
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0;
    write_en1 = 1'b0; write_en2 = 1'b0; read_en1 = 1'b0; read_en2 = 1'b0;
    write_pc1 = '0; write_pc2 = '0; write_inst1 = '0; write_inst2 = '0;
    write_excp1 = 1'b0; write_excp2 = 1'b0;
    next_pc = 32'hBFC0_0000;
    #12;
    check_outputs("reset");
    resetn = 1'b1;
    @(posedge clk); #1;

    // Dual push from empty, visible next cycle.
    cycle("push2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("push2.mpc_const", master_pc, 32'hBFC0_0000);
    chk("push2.spc_const", slave_pc,  32'hBFC0_0004);
    chk("push2.cnt_const", 32'(count), 32'd2);

    // cnt=3: pop 2 and push 2 together.
    cycle("push1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("pp22", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("pp22.mpc_const", master_pc, 32'hBFC0_0008);
    chk("pp22.cnt_const", 32'(count), 32'd3);

    // Dual pop with a single entry pops just one.
    cycle("pop2a", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle("pop2b", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("pop1only.empty", 32'(empty), 32'd1);
    chk("pop1only.sv", 32'(slave_valid), 32'd0);

    // read_en2 / write_en2 alone are ignored.
    cycle("we2only", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("fill0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("re2only", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("drain0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Fill to 14, then 15, then overflow on the second entry.
    for (int i = 0; i < 7; i++) cycle("fill", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("fill14.af", 32'(almost_full), 32'd1);
    cycle("fill15", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("fill16", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("fill16.cnt_const", 32'(count), 32'd16);
    cycle("full_drop", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("full_pp", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Drain to 5, then flush against a push and a pop.
    for (int i = 0; i < 5; i++) cycle("drain", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle("drain5", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("pre_flush.cnt", 32'(count), 32'd5);
    cycle("flush", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("flush.mi_const", master_inst, 32'd0);
    saved_pc = next_pc;
    cycle("post_flush", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_flush.mpc", master_pc, saved_pc);

    // Mixed traffic with pointers wrapping several times.
    for (int i = 0; i < 40; i++) begin
      cycle("wrap", 1'b1, (i % 3) != 0, 1'b1, (i % 4) != 1, 1'b0);
      if (slave_valid) chk("wrap.order", 32'(slave_pc > master_pc), 32'd1);
    end

    // Asynchronous reset mid-cycle.
    cycle("pre_rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #3 resetn = 1'b0;
    #1;
    sb.delete();
    check_outputs("async_rst");
    #2 resetn = 1'b1;
    @(posedge clk); #1;
    cycle("after_rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
